// File: rtl/tetris_drop_ctrl.sv
// Falling-piece sequencer: picks a piece from an LFSR, applies frame-tick gravity,
// detects landing and holds the landed piece before respawning.
module tetris_drop_ctrl #(
    parameter int         FALL_FRAMES = 30,
    parameter int         FAST_FRAMES = 3,
    parameter int         LAND_FRAMES = 20,
    parameter int         STEP        = 32,
    parameter int         V_RES       = 480,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       drop_fast,
    output logic [2:0] piece_type,
    output logic [8:0] position,
    output logic       piece_valid,
    output logic       landed,
    output logic [7:0] piece_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        FALL  = 3'd2,
        LAND  = 3'd3
    } state_t;

    localparam int MAX_FR = (FALL_FRAMES > FAST_FRAMES)
        ? ((FALL_FRAMES > LAND_FRAMES) ? FALL_FRAMES : LAND_FRAMES)
        : ((FAST_FRAMES > LAND_FRAMES) ? FAST_FRAMES : LAND_FRAMES);
    localparam int CNT_W = $clog2(MAX_FR + 1);

    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_FRAMES - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_FRAMES - 1);
    localparam logic [CNT_W-1:0] LAND_LAST = CNT_W'(LAND_FRAMES - 1);
    localparam logic [9:0]       STEP_W    = 10'(STEP);
    localparam logic [9:0]       VRES_W    = 10'(V_RES);

    // Fibonacci form of x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [2:0] map_type(input logic [2:0] r);
        return (r == 3'd7) ? 3'd0 : r;
    endfunction

    function automatic logic [9:0] piece_height(input logic [2:0] t);
        case (t)
            3'd0:    return 10'd128;
            3'd3:    return 10'd64;
            default: return 10'd96;
        endcase
    endfunction

    state_t           st;
    logic [7:0]       lfsr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] step_lim;
    logic [9:0]       pos_next;
    logic [9:0]       max_pos;

    assign state    = st;
    assign step_lim = drop_fast ? FAST_LAST : FALL_LAST;
    // 10-bit sum so a step past the bottom is seen rather than wrapping
    assign pos_next = {1'b0, position} + STEP_W;
    assign max_pos  = VRES_W - piece_height(piece_type);

    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= IDLE;
            position    <= '0;
            piece_type  <= '0;
            piece_valid <= 1'b0;
            landed      <= 1'b0;
            piece_count <= '0;
            cnt         <= '0;
            lfsr        <= SEED;
        end else begin
            lfsr   <= lfsr_step(lfsr);
            landed <= 1'b0;
            case (st)
                IDLE: begin
                    piece_valid <= 1'b0;
                    if (start) st <= SPAWN;
                end
                SPAWN: begin
                    piece_type  <= map_type(lfsr[2:0]);
                    position    <= '0;
                    cnt         <= '0;
                    piece_count <= piece_count + 8'd1;
                    piece_valid <= 1'b1;
                    st          <= FALL;
                end
                FALL: begin
                    piece_valid <= 1'b1;
                    // >= so a drop_fast change mid-count takes effect on the next tick
                    if (frame_tick && !pause) begin
                        if (cnt >= step_lim) begin
                            cnt <= '0;
                            if (pos_next <= max_pos) begin
                                position <= pos_next[8:0];
                            end else begin
                                landed <= 1'b1;
                                st     <= LAND;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LAND: begin
                    piece_valid <= 1'b1;
                    if (frame_tick) begin
                        if (cnt >= LAND_LAST) begin
                            cnt         <= '0;
                            piece_valid <= 1'b0;
                            st          <= SPAWN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_drop_ctrl.sv
// Directed bench for tetris_drop_ctrl: vector table for a full fall/land cycle,
// plus sequences for pause, gravity switch, mid-fall reset and the LFSR piece order.
module tb_tetris_drop_ctrl;

    localparam int         FALL_FRAMES = 2;
    localparam int         FAST_FRAMES = 3;
    localparam int         LAND_FRAMES = 3;
    localparam logic [7:0] SEED        = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       drop_fast = 1'b0;
    logic [2:0] piece_type;
    logic [8:0] position;
    logic       piece_valid;
    logic       landed;
    logic [7:0] piece_count;
    logic [2:0] state;

    tetris_drop_ctrl #(
        .FALL_FRAMES(FALL_FRAMES),
        .FAST_FRAMES(FAST_FRAMES),
        .LAND_FRAMES(LAND_FRAMES),
        .STEP(32),
        .V_RES(480),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .start(start),
        .pause(pause),
        .drop_fast(drop_fast),
        .piece_type(piece_type),
        .position(position),
        .piece_valid(piece_valid),
        .landed(landed),
        .piece_count(piece_count),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pause;
        logic fast;
        int   st;
        int   pos;
        logic vld;
        logic lnd;
    } vec_t;

    vec_t vecs[29];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, new bit at LSB
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    function automatic int ref_type(input logic [7:0] s);
        int r;
        r = int'(s[2:0]);
        return (r == 7) ? 0 : r;
    endfunction

    function automatic int ref_max(input int t);
        if (t == 0) return 352;
        if (t == 3) return 416;
        return 384;
    endfunction

    logic [7:0] ref_lfsr = SEED;
    always @(posedge clk) begin
        if (!rst) ref_lfsr <= SEED;
        else      ref_lfsr <= ref_next(ref_lfsr);
    end

    int n_landed = 0;
    always @(negedge clk) if (landed === 1'b1) n_landed <= n_landed + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        repeat (9) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int land0;
        int exp_t, steps, fall_cyc, g, prev;

        for (int n = 1; n <= 25; n++) vecs[n-1] = '{1'b0, 1'b0, 2, 32 * (n / 2), 1'b1, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 3, 384, 1'b1, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 3, 384, 1'b1, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 3, 384, 1'b1, 1'b0};
        vecs[28] = '{1'b0, 1'b0, 1, 384, 1'b0, 1'b0};

        // Reset and idle hold
        repeat (3) @(negedge clk);
        chk("rst.state", state, 0);
        chk("rst.position", position, 0);
        chk("rst.piece_type", piece_type, 0);
        chk("rst.piece_count", piece_count, 0);
        chk("rst.landed", landed, 0);
        rst = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (state != 3'd0 || position != 9'd0 || piece_valid != 1'b0) bad++;
        end
        chk("idle.bad_cycles", bad, 0);

        // Restart from reset so the first spawn sees LFSR step 1 (0x4A -> L piece)
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start.state", state, 1);
        @(negedge clk);
        chk("spawn.state", state, 2);
        chk("spawn.piece_type", piece_type, 2);
        chk("spawn.piece_count", piece_count, 1);
        chk("spawn.valid", piece_valid, 1);

        land0 = n_landed;
        for (int i = 0; i < 29; i++) begin
            pause = vecs[i].pause;
            drop_fast = vecs[i].fast;
            tick();
            chk($sformatf("v%0d.state", i), state, vecs[i].st);
            chk($sformatf("v%0d.position", i), position, vecs[i].pos);
            chk($sformatf("v%0d.valid", i), piece_valid, vecs[i].vld);
            chk($sformatf("v%0d.landed", i), landed, vecs[i].lnd);
        end
        @(negedge clk);
        chk("respawn.state", state, 2);
        chk("respawn.piece_count", piece_count, 2);
        chk("respawn.position", position, 0);
        chk("fall.landed_pulses", n_landed - land0, 1);

        // Pause freezes counter and position
        tick();
        chk("pre_pause.position", position, 0);
        pause = 1'b1;
        repeat (50) tick();
        chk("pause.position", position, 0);
        chk("pause.state", state, 2);
        pause = 1'b0;
        tick();
        chk("unpause.position", position, 32);

        // Counter above new limit steps on the next tick
        drop_fast = 1'b1;
        tick();
        tick();
        chk("fast_count.position", position, 32);
        drop_fast = 1'b0;
        tick();
        chk("switch.position", position, 64);
        repeat (6) tick();
        chk("mid.position", position, 160);

        // Reset mid-fall
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.state", state, 0);
        chk("midrst.position", position, 0);
        chk("midrst.piece_count", piece_count, 0);
        chk("midrst.valid", piece_valid, 0);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst.seed_type", piece_type, 2);
        chk("midrst.count1", piece_count, 1);

        // 20 spawns under continuous fast gravity against the reference LFSR
        drop_fast = 1'b1;
        frame_tick = 1'b1;
        for (int s = 0; s < 20; s++) begin
            g = 0;
            while (state != 3'd1 && g < 500) begin
                @(negedge clk);
                g++;
            end
            chk($sformatf("seq%0d.spawn_reached", s), state, 1);
            if (state != 3'd1) break;
            exp_t = ref_type(ref_lfsr);
            @(negedge clk);
            chk($sformatf("seq%0d.piece_type", s), piece_type, exp_t);
            chk($sformatf("seq%0d.not7", s), (piece_type != 3'd7) ? 1 : 0, 1);
            steps = 0;
            fall_cyc = 0;
            prev = 0;
            g = 0;
            while (state == 3'd2 && g < 500) begin
                fall_cyc++;
                @(negedge clk);
                g++;
                if (position != prev[8:0]) begin
                    steps++;
                    prev = int'(position);
                end
            end
            chk($sformatf("seq%0d.landed", s), landed, 1);
            chk($sformatf("seq%0d.land_pos", s), position, ref_max(exp_t));
            chk($sformatf("seq%0d.steps", s), steps, ref_max(exp_t) / 32);
            chk($sformatf("seq%0d.fall_cycles", s), fall_cyc, FAST_FRAMES * (ref_max(exp_t) / 32 + 1));
        end
        frame_tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
